// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Multi-cycle data-memory target for the CPU load/store port. It accepts one
//   word request at a time and holds it for LATENCY wait cycles. It then
//   performs the access against a DEPTH x 32-bit array and presents the
//   registered response until the CPU takes it.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   high. The request side is ready only in IDLE, and valid outside that edge
//   is ignored. The response side holds valid, rdata and err stable from the
//   access edge until the edge where resp_ready_i is high. resp_ready_i is
//   ignored outside RESP.
//
// Optional feature macro: DMEM_BYTE_WRITE_EN
//   When defined, adds req_be_i (per-byte store enables latched at accept).
//   When undefined, every store writes all four bytes.
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_i         asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   responder can accept a request (state == IDLE)
//   req_write_i   1 = store, 0 = load
//   req_addr_i    byte address; word index = addr[31:2]
//   req_wdata_i   store data
//   req_be_i      byte enables (only with DMEM_BYTE_WRITE_EN)
//   resp_valid_o  response present
//   resp_ready_i  CPU consumes the response
//   resp_rdata_o  load data; 0 for stores and on error
//   resp_err_o    request was misaligned or out of range
//   busy_o        state is not IDLE
//   dbg_state_o   current FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  req_be_i,
`endif
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH];

  logic [3:0]       w_req_be;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic             w_access;
  logic             w_we;

`ifdef DMEM_BYTE_WRITE_EN
  assign w_req_be = req_be_i;
`else
  assign w_req_be = 4'hF;
`endif

  // Checks use the latched address, so a request that changes after the
  // accept edge cannot affect the access.
  assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));
  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_we     = w_access && r_write && !w_err;

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  // Control FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= 32'd0;
      resp_err_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_write <= req_write_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_be    <= w_req_be;
            r_cnt   <= 4'(LATENCY);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            resp_valid_o <= 1'b1;
            if (w_err) begin
              resp_err_o   <= 1'b1;
              resp_rdata_o <= 32'd0;
            end else if (r_write) begin
              resp_err_o   <= 1'b0;
              resp_rdata_o <= 32'd0;
            end else begin
              resp_err_o   <= 1'b0;
              resp_rdata_o <= r_mem[w_idx];
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // rdata/err intentionally keep their value after the handshake.
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage array. It is cleared by reset. A reset that arrives mid-transaction
  // wins over the pending write because the write only happens on the access edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (r_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i  = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic [3:0]  req_be_i    = 4'hF;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be_i     (req_be_i),
`endif
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  // ---------------- driver ----------------
  // Drives one request, waits for the response, applies hold cycles of
  // back-pressure and then completes the handshake.
  task automatic run_txn(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int hold);
    logic [32:0] e;
    logic [31:0] idx;
    logic [3:0]  eb;
    int edges;
    eb = be;
`ifndef DMEM_BYTE_WRITE_EN
    eb = 4'hF;
`endif
    idx = {2'b00, addr[31:2]};
    if (addr[1:0] != 2'b00 || idx >= DEPTH) begin
      e = {1'b1, 32'd0};
    end else if (wr) begin
      for (int k = 0; k < 4; k++)
        if (eb[k]) model_mem[idx][8*k +: 8] = wdata[8*k +: 8];
      e = {1'b0, 32'd0};
    end else begin
      e = {1'b0, model_mem[idx]};
    end
    exp_q.push_back(e);

    @(negedge clk_i);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    @(posedge clk_i);
    @(negedge clk_i);
    // Garbage on the request bus after accept must be ignored.
    req_valid_i = 1'b0;
    req_write_i = ~wr;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_be_i    = 4'($urandom_range(0, 15));
    chk("busy_after_accept", busy_o, 1);
    edges = 0;
    while (!resp_valid_o && edges < 40) begin
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
    end
    if (!resp_valid_o) begin
      chk("resp_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    chk("latency", edges, LATENCY + 1);
    e = exp_q.pop_front();
    chk("rdata", resp_rdata_o, e[31:0]);
    chk("err", resp_err_o, e[32]);
    chk("req_ready_resp", req_ready_o, 0);
    repeat (hold) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("hold_valid", resp_valid_o, 1);
      chk("hold_rdata", resp_rdata_o, e[31:0]);
      chk("hold_err", resp_err_o, e[32]);
      chk("hold_req_ready", req_ready_o, 0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("valid_after_hs", resp_valid_o, 0);
    chk("ready_after_hs", req_ready_o, 1);
    chk("busy_after_hs", busy_o, 0);
    chk("rdata_kept", resp_rdata_o, e[31:0]);
    chk("err_kept", resp_err_o, e[32]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    clear_model();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    chk("rst_err", resp_err_o, 0);
    rst_i = 1'b1;

    // Basic load, then store and read back.
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
    run_txn(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0);
    run_txn(1'b0, 32'h8, 32'h0, 4'hF, 0);

    // Errors do not disturb stored data.
    run_txn(1'b1, 32'h0, 32'h11111111, 4'hF, 0);
    run_txn(1'b0, 32'h6, 32'h0, 4'hF, 0);
    run_txn(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 0);
    run_txn(1'b0, 32'h1FC, 32'h0, 4'hF, 0);
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0);

    // Back-pressure on a load.
    run_txn(1'b0, 32'h8, 32'h0, 4'hF, 5);

    // Reset in the middle of a store.
    run_txn(1'b1, 32'h4, 32'h55AA55AA, 4'hF, 0);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h0;
    req_wdata_i = 32'h12345678;
    req_be_i    = 4'hF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("busy_before_reset", busy_o, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("busy_in_reset", busy_o, 0);
    chk("ready_in_reset", req_ready_o, 1);
    #1 rst_i = 1'b1;
    clear_model();
    repeat (6) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("no_resp_after_reset", resp_valid_o, 0);
    end
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0);
    run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0);

`ifdef DMEM_BYTE_WRITE_EN
    run_txn(1'b1, 32'h4, 32'hFFFFFFFF, 4'b1111, 0);
    run_txn(1'b1, 32'h4, 32'h00AB0000, 4'b0100, 0);
    run_txn(1'b0, 32'h4, 32'h0, 4'b0000, 0);
    run_txn(1'b1, 32'h4, 32'h00000000, 4'b0000, 0);
    run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0);
`endif

    // Random mix; the scoreboard model tracks memory contents.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h200 + 32'($urandom_range(0, 64));
      else if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 63));
      else a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the CPU's load/store interface.
- Replaces the zero-wait combinational data memory when the CPU is moved to a handshaked, stall-capable memory port.
- Accepts one word request at a time over a valid/ready request channel.
- Holds the request for a programmable number of wait cycles, performs the access, then returns a response over a valid/ready response channel.

Parameters:
- DEPTH, 128, number of 32-bit words stored; word index = addr_i[31:2].
- LATENCY, 2, wait cycles in BUSY before the access (legal 0..15).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data.
- resp_valid_o  output  1  response present.
- resp_ready_i  input  1  CPU consumes the response.
- resp_rdata_o  output  32  load data; 0 for stores and on error.
- resp_err_o  output  1  request was misaligned or out of range.
- busy_o  output  1  state is not IDLE.

Behaviour:
- States: IDLE, BUSY, RESP. Encoding is free.
- Reset (rst_i low, asynchronous):
  - State goes to IDLE; the wait counter clears to 0.
  - All DEPTH words clear to 0.
  - req_ready_o=1 and busy_o=0, since both are decoded from IDLE.
  - Registered outputs resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - Reset mid-transaction discards the request: no write occurs and no response is produced.
- IDLE:
  - req_ready_o=1.
  - Accept on an edge where req_valid_i=1. Latch write, addr and wdata, load counter=LATENCY, go BUSY.
  - Request inputs are ignored outside the accept edge.
- BUSY:
  - req_ready_o=0.
  - Counter decrements each edge while nonzero.
  - On the edge where counter==0: perform the access, register the response, go RESP.
  - Acceptance at edge E0 gives resp_valid_o high after edge E0+LATENCY+1. LATENCY=0 therefore gives a 1-cycle gap.
- Access rules:
  - Error if latched addr[1:0]!=0 or addr[31:2]>=DEPTH. Error sets resp_err_o=1, resp_rdata_o=0, no write.
  - Store: mem[index]<=wdata, resp_rdata_o=0, resp_err_o=0.
  - Load: resp_rdata_o=mem[index], resp_err_o=0.
  - Load-after-store to the same address in back-to-back transactions returns the new data.
- RESP:
  - resp_valid_o=1; resp_rdata_o and resp_err_o are held stable until the handshake.
  - On an edge with resp_ready_i=1: clear resp_valid_o, go IDLE.
  - resp_rdata_o and resp_err_o keep their last value until the next access.
  - req_ready_o=0 in RESP. No request overlap; the next request is accepted at the earliest one edge after the response handshake.
- Only one outstanding transaction. req_valid_i held high while req_ready_o=0 has no effect.
- resp_ready_i asserted outside RESP is ignored.
- busy_o = (state!=IDLE).

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined:
  - Adds port req_be_i, input, 4 bits, byte enables latched at accept.
  - A store writes only bytes whose enable is 1; bit k selects byte [8k+7:8k].
  - be=0000 is a legal no-op store with resp_err_o=0.
  - Loads ignore be and return the full word.
  - Alignment and range checks are unchanged.
- Undefined: port absent; every store writes all 4 bytes.

Test Plan:
- Reset, then load addr 0x00000010 with LATENCY=2 -> resp_valid_o rises 3 edges after the accept edge; resp_rdata_o=0x00000000, resp_err_o=0.
- Store 0xDEADBEEF to 0x00000008, handshake, then load 0x00000008 -> resp_rdata_o=0xDEADBEEF, resp_err_o=0.
- Load 0x00000006 (misaligned), then store to 0x00000200 with DEPTH=128 (out of range) -> both give resp_err_o=1 and resp_rdata_o=0. A later load of word 0 still returns its prior value.
- Back-pressure: hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o, resp_rdata_o and resp_err_o stay stable and req_ready_o stays 0. Asserting resp_ready_i returns the block to IDLE next edge.
- Pulse rst_i low during BUSY of a store of 0x12345678 to 0x0 -> state IDLE, resp_valid_o never asserts, and a later load of 0x0 returns 0x00000000.
- With DMEM_BYTE_WRITE_EN: store 0xFFFFFFFF be=1111, then store 0x00AB0000 be=0100 to 0x4 -> a load of 0x4 returns 0xFFABFFFF.
